sisc_ctrl_fsm: RTL

Parametrised control FSM for the SISC CPU, successor of the fixed 4-bit multicycle controller. Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK, drives datapath selects and write enables, and evaluates conditional branches. Also adds:
- a data-memory ready handshake with wait states;
- a real HALT state in place of a simulation stop;
- an optional fast path that skips unused cycles.

---
 rtl/sisc_pkg.sv | 35 +++
 rtl/sisc_br_eval.sv | 27 ++
 rtl/sisc_ctrl_fsm.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, addressing-mode constant, controller states
// and ALU/address operation encodings used by the controller and the datapath.
package sisc_pkg;

  localparam int unsigned OP_NOOP = 0;
  localparam int unsigned OP_LOD  = 1;
  localparam int unsigned OP_STR  = 2;
  localparam int unsigned OP_SWP  = 3;
  localparam int unsigned OP_BRA  = 4;
  localparam int unsigned OP_BRR  = 5;
  localparam int unsigned OP_BNE  = 6;
  localparam int unsigned OP_BNR  = 7;
  localparam int unsigned OP_ALU  = 8;
  localparam int unsigned OP_HLT  = 15;

  // Immediate addressing mode value of the mm field.
  localparam int unsigned AM_IMM = 8;

  typedef enum logic [2:0] {
    RESET,
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WRITEBACK,
    HALT
  } state_t;

  // ALU_OP uses the ALU proper; every other opcode uses the address adder.
  localparam logic [1:0] ALU_OP_REG  = 2'b00;
  localparam logic [1:0] ALU_OP_IMM  = 2'b01;
  localparam logic [1:0] ADDR_OP_REG = 2'b10;
  localparam logic [1:0] ADDR_OP_IMM = 2'b11;

endpackage

// File: rtl/sisc_br_eval.sv
// Conditional-branch evaluator: taken = f(opcode, mm, stat).
// BRA/BRR branch when any masked status bit is set, BNE/BNR when none is.
module sisc_br_eval
  import sisc_pkg::*;
#(
  parameter int OPW = 4,
  parameter int CCW = 4
) (
  input  logic [OPW-1:0] opcode,
  input  logic [CCW-1:0] mm,
  input  logic [CCW-1:0] stat,
  output logic           taken
);

  logic hit;

  always_comb begin
    hit   = |(stat & mm);
    taken = 1'b0;
    if (opcode == OPW'(OP_BRA) || opcode == OPW'(OP_BRR)) begin
      taken = hit;
    end else if (opcode == OPW'(OP_BNE) || opcode == OPW'(OP_BNR)) begin
      taken = !hit;
    end
  end

endmodule

// File: rtl/sisc_ctrl_fsm.sv
// SISC multicycle control FSM with data-memory wait states and a HALT state.
// Define SISC_CTRL_FASTPATH_EN to skip cycles that an instruction does not use.
module sisc_ctrl_fsm
  import sisc_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int CCW  = 4,
  parameter int ALUW = 2
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic [OPW-1:0]  opcode,
  input  logic [CCW-1:0]  mm,
  input  logic [CCW-1:0]  stat,
  input  logic            mem_ready,
  output logic            rf_we,
  output logic            wb_sel,
  output logic            rb_sel,
  output logic [ALUW-1:0] alu_op,
  output logic            pc_sel,
  output logic            br_sel,
  output logic            pc_write,
  output logic            pc_rst,
  output logic            ir_load,
  output logic            mux_16_sel,
  output logic            dm_we,
  output logic            halted,
  output logic            instr_done
);

  state_t state, state_nxt;

  logic is_lod, is_str, is_mem, is_br, is_abs_br, is_alu, is_hlt, imm, taken;
  logic fast_exit, skip_mem;
  logic [ALUW-1:0] alu_code;

  assign is_lod    = (opcode == OPW'(OP_LOD));
  assign is_str    = (opcode == OPW'(OP_STR));
  assign is_mem    = is_lod | is_str;
  assign is_abs_br = (opcode == OPW'(OP_BRA)) | (opcode == OPW'(OP_BNE));
  assign is_br     = is_abs_br | (opcode == OPW'(OP_BRR)) | (opcode == OPW'(OP_BNR));
  assign is_alu    = (opcode == OPW'(OP_ALU));
  assign is_hlt    = (opcode == OPW'(OP_HLT));
  assign imm       = (mm == CCW'(AM_IMM));

  always_comb begin
    if (is_alu) alu_code = imm ? ALUW'(ALU_OP_IMM)  : ALUW'(ALU_OP_REG);
    else        alu_code = imm ? ALUW'(ADDR_OP_IMM) : ALUW'(ADDR_OP_REG);
  end

`ifdef SISC_CTRL_FASTPATH_EN
  logic is_swp, is_noop;
  assign is_swp    = (opcode == OPW'(OP_SWP));
  // Unlisted opcodes behave as NOOP and take the short path too.
  assign is_noop   = !(is_mem | is_swp | is_br | is_alu | is_hlt);
  assign fast_exit = is_br | is_noop;
  assign skip_mem  = !is_mem;
`else
  assign fast_exit = 1'b0;
  assign skip_mem  = 1'b0;
`endif

  sisc_br_eval #(
    .OPW (OPW),
    .CCW (CCW)
  ) u_br_eval (
    .opcode (opcode),
    .mm     (mm),
    .stat   (stat),
    .taken  (taken)
  );

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; the reset is synchronous and wins over any transition.
  always_ff @(posedge clk) begin
    if (!rst_f) state <= RESET;
    else        state <= state_nxt;
  end

  // NOTE: every output and the next state get a default before the case so
  // no path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_nxt  = state;
    rf_we      = 1'b0;
    wb_sel     = 1'b0;
    rb_sel     = 1'b0;
    alu_op     = '0;
    pc_sel     = 1'b0;
    br_sel     = 1'b0;
    pc_write   = 1'b0;
    pc_rst     = 1'b0;
    ir_load    = 1'b0;
    mux_16_sel = 1'b0;
    dm_we      = 1'b0;
    halted     = 1'b0;
    instr_done = 1'b0;

    unique case (state)
      RESET: begin
        pc_rst    = 1'b1;
        state_nxt = FETCH;
      end
      FETCH: begin
        pc_write  = 1'b1;
        ir_load   = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: begin
        if (is_br) begin
          pc_sel   = 1'b1;
          br_sel   = is_abs_br;
          pc_write = taken;
        end
        if (is_hlt) begin
          state_nxt = HALT;
        end else if (fast_exit) begin
          instr_done = 1'b1;
          state_nxt  = FETCH;
        end else begin
          state_nxt = EXECUTE;
        end
      end
      EXECUTE: begin
        alu_op    = alu_code;
        rb_sel    = is_str;
        state_nxt = skip_mem ? WRITEBACK : MEM;
      end
      MEM: begin
        alu_op     = alu_code;
        rb_sel     = is_str;
        dm_we      = is_str;
        wb_sel     = is_lod;
        mux_16_sel = is_mem && (mm == '0);
        // Only loads and stores wait on the memory handshake.
        if (!is_mem || mem_ready) state_nxt = WRITEBACK;
      end
      WRITEBACK: begin
        alu_op     = alu_code;
        wb_sel     = is_lod;
        rf_we      = is_alu | is_lod;
        instr_done = 1'b1;
        state_nxt  = FETCH;
      end
      HALT: begin
        halted    = 1'b1;
        state_nxt = HALT;
      end
      default: state_nxt = RESET;
    endcase
  end

endmodule
